// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC capture block.
// The helper below is only referenced when ADC_CAPTURE_OVERRANGE_EN is defined.
package adc_pkg;
    localparam int LANES    = 8;
    localparam int SAMPLE_W = 16;
    localparam int BEAT_W   = LANES * SAMPLE_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } adc_state_t;

    // Number of lanes sitting at either full-scale code.
    function automatic logic [3:0] count_overrange(input logic [BEAT_W-1:0] beat);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            if (beat[i*SAMPLE_W +: SAMPLE_W] == 16'h7fff || beat[i*SAMPLE_W +: SAMPLE_W] == 16'h8000)
                n = n + 4'd1;
        end
        return n;
    endfunction
endpackage

// File: rtl/adc_capture_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port.
// A same-address read and write in one cycle returns the previous contents.
module adc_capture_ram
    import adc_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              adc_axi_clk,
    input  logic              RESET,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BEAT_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BEAT_W-1:0] rd_data
);
    logic [BEAT_W-1:0] mem [DEPTH];

    always_ff @(posedge adc_axi_clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
    end

    // Only the output register is reset; the array is left as-is.
    always_ff @(posedge adc_axi_clk) begin
        if (RESET)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/adc_capture.sv
// Triggered ADC beat capture into a DEPTH x 128 buffer with registered readout.
// Define ADC_CAPTURE_OVERRANGE_EN to add the saturating overrange_cnt output.
module adc_capture
    import adc_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              adc_axi_clk,
    input  logic              RESET,
    input  logic [BEAT_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              arm,
    input  logic [15:0]       trig_level,
    output logic              cap_done,
    output logic [ADDR_W:0]   cap_cnt,
    output logic [2:0]        trig_lane,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BEAT_W-1:0] rd_data,
`ifdef ADC_CAPTURE_OVERRANGE_EN
    output logic [15:0]       overrange_cnt,
`endif
    output adc_state_t        cap_state
);
    // Handshake: a beat transfers on any rising edge where s_axis_tvalid and
    // s_axis_tready are both high; tready is high in every state outside reset.
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    adc_state_t        state;
    logic [15:0]       level_q;
    logic [LANES-1:0]  lane_hit;
    logic [2:0]        hit_lane;
    logic              accept, trig_beat, cap_wr, we, last_wr;
    logic [ADDR_W-1:0] wr_addr;

    always_comb begin
        lane_hit = '0;
        for (int i = 0; i < LANES; i++)
            lane_hit[i] = $signed(s_axis_tdata[i*SAMPLE_W +: SAMPLE_W]) > $signed(level_q);
    end

    // Lowest triggering lane wins.
    always_comb begin
        hit_lane = '0;
        for (int i = LANES - 1; i >= 0; i--)
            if (lane_hit[i])
                hit_lane = 3'(i);
    end

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign trig_beat = accept && (state == ST_ARMED) && (|lane_hit);
    assign cap_wr    = accept && (state == ST_CAPTURE) && (cap_cnt != DEPTH_CNT);
    assign we        = trig_beat || cap_wr;
    assign wr_addr   = trig_beat ? '0 : cap_cnt[ADDR_W-1:0];
    assign last_wr   = (cap_cnt + 1'b1) == DEPTH_CNT;
    assign cap_state = state;

    always_ff @(posedge adc_axi_clk) begin
        if (RESET) begin
            state         <= ST_IDLE;
            s_axis_tready <= 1'b0;
            cap_done      <= 1'b0;
            cap_cnt       <= '0;
            trig_lane     <= '0;
            level_q       <= '0;
        end else begin
            s_axis_tready <= 1'b1;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state     <= ST_ARMED;
                        cap_done  <= 1'b0;
                        cap_cnt   <= '0;
                        trig_lane <= '0;
                        level_q   <= trig_level;
                    end
                end
                ST_ARMED: begin
                    if (trig_beat) begin
                        trig_lane <= hit_lane;
                        cap_cnt   <= (ADDR_W+1)'(1);
                        if (DEPTH_CNT == (ADDR_W+1)'(1)) begin
                            state    <= ST_DONE;
                            cap_done <= 1'b1;
                        end else begin
                            state <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (cap_wr) begin
                        cap_cnt <= cap_cnt + 1'b1;
                        if (last_wr) begin
                            state    <= ST_DONE;
                            cap_done <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ADC_CAPTURE_OVERRANGE_EN
    logic [16:0] ovr_sum;
    assign ovr_sum = {1'b0, overrange_cnt} + 17'(count_overrange(s_axis_tdata));

    always_ff @(posedge adc_axi_clk) begin
        if (RESET)
            overrange_cnt <= '0;
        else if (arm && (state == ST_IDLE || state == ST_DONE))
            overrange_cnt <= '0;
        else if (we)
            overrange_cnt <= ovr_sum[16] ? 16'hffff : ovr_sum[15:0];
    end
`endif

    adc_capture_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .adc_axi_clk (adc_axi_clk),
        .RESET       (RESET),
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_data     (s_axis_tdata),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );
endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture: trigger vector table, directed corner
// sequences and randomized traffic against a queue-based capture model.
module tb_adc_capture;
  import adc_pkg::*;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  // clock / reset block
  logic adc_axi_clk = 1'b0;
  always #5 adc_axi_clk = ~adc_axi_clk;

  logic              RESET = 1'b1;
  logic [127:0]      s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic              arm = 1'b0;
  logic [15:0]       trig_level = '0;
  logic              cap_done;
  logic [ADDR_W:0]   cap_cnt;
  logic [2:0]        trig_lane;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [127:0]      rd_data;
  adc_state_t        cap_state;
`ifdef ADC_CAPTURE_OVERRANGE_EN
  logic [15:0]       overrange_cnt;
`endif

  adc_capture #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .adc_axi_clk   (adc_axi_clk),
    .RESET         (RESET),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .arm           (arm),
    .trig_level    (trig_level),
    .cap_done      (cap_done),
    .cap_cnt       (cap_cnt),
    .trig_lane     (trig_lane),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
`ifdef ADC_CAPTURE_OVERRANGE_EN
    .overrange_cnt (overrange_cnt),
`endif
    .cap_state     (cap_state)
  );

  int checks = 0;
  int failures = 0;
  logic [127:0] exp_q[$];

  // reference model: the capture is simply the ordered list of stored beats
  bit           m_ready = 0;
  bit           m_waiting = 0;
  bit           m_active = 0;
  logic [127:0] m_buf[$];
  int           m_lane = 0;
  logic [15:0]  m_level = '0;
  logic [127:0] m_mem[DEPTH];
  bit           m_valid[DEPTH];
  int           m_ovr = 0;
  logic [127:0] m_rd = '0;
  bit           m_rd_ok = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_hit(input logic [127:0] d, input logic [15:0] lvl);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] s;
      s = d[i*16 +: 16];
      if ($signed(s) > $signed(lvl)) return i;
    end
    return -1;
  endfunction

  function automatic int ovr_lanes(input logic [127:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] s;
      s = d[i*16 +: 16];
      if (s == 16'h7fff || s == 16'h8000) n++;
    end
    return n;
  endfunction

  function automatic logic [127:0] mk(input int lane, input logic [15:0] val, input logic [15:0] fill);
    logic [127:0] d;
    for (int i = 0; i < 8; i++) d[i*16 +: 16] = (i == lane) ? val : fill;
    return d;
  endfunction

  function automatic logic [127:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_store(input logic [127:0] d);
    int a;
    a = m_buf.size();
    m_mem[a] = d;
    m_valid[a] = 1;
    m_buf.push_back(d);
    m_ovr = m_ovr + ovr_lanes(d);
    if (m_ovr > 65535) m_ovr = 65535;
  endtask

  // advance model and DUT by one clock, then compare all outputs
  task automatic cycle();
    bit acc, can_arm, done;
    int h;
    adc_state_t exp_state;
    if (RESET) begin
      m_ready = 0; m_waiting = 0; m_active = 0; m_buf.delete();
      m_lane = 0; m_level = '0; m_ovr = 0; m_rd = '0; m_rd_ok = 1;
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
    end else begin
      m_rd = m_mem[rd_addr];
      m_rd_ok = m_valid[rd_addr];
      acc = s_axis_tvalid && m_ready;
      can_arm = !m_waiting && !(m_active && m_buf.size() < DEPTH);
      if (arm && can_arm) begin
        m_waiting = 1; m_active = 0; m_buf.delete();
        m_lane = 0; m_level = trig_level; m_ovr = 0;
      end else if (acc && m_waiting) begin
        h = first_hit(s_axis_tdata, m_level);
        if (h >= 0) begin
          m_waiting = 0; m_active = 1; m_lane = h;
          model_store(s_axis_tdata);
        end
      end else if (acc && m_active && m_buf.size() < DEPTH) begin
        model_store(s_axis_tdata);
      end
      m_ready = 1;
    end
    @(posedge adc_axi_clk);
    #1;
    done = m_active && (m_buf.size() == DEPTH);
    if (m_waiting) exp_state = ST_ARMED;
    else if (done) exp_state = ST_DONE;
    else if (m_active) exp_state = ST_CAPTURE;
    else exp_state = ST_IDLE;
    check("tready", s_axis_tready, m_ready);
    check("state", cap_state, exp_state);
    check("cap_done", cap_done, done);
    check("cap_cnt", cap_cnt, m_buf.size());
    check("trig_lane", trig_lane, m_lane);
    if (m_rd_ok) check("rd_data", rd_data, m_rd);
`ifdef ADC_CAPTURE_OVERRANGE_EN
    check("overrange_cnt", overrange_cnt, m_ovr);
`endif
  endtask

  // driver tasks
  task automatic do_reset(input int n);
    RESET = 1; arm = 0; s_axis_tvalid = 0;
    repeat (n) cycle();
    RESET = 0;
  endtask

  task automatic do_arm(input logic [15:0] lvl);
    arm = 1; trig_level = lvl; s_axis_tvalid = 0;
    cycle();
    arm = 0;
  endtask

  task automatic send(input logic [127:0] d);
    s_axis_tvalid = 1; s_axis_tdata = d;
    cycle();
    s_axis_tvalid = 0;
  endtask

  typedef struct {
    logic [15:0]  level;
    logic [127:0] beat;
    bit           exp_trig;
    logic [2:0]   exp_lane;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{16'h1000, mk(-1, 16'h0000, 16'h0000), 0, 3'd0};
    vecs[1] = '{16'h1000, mk(5, 16'h2000, 16'h0000), 1, 3'd5};
    vecs[2] = '{16'h0000, mk(-1, 16'h0000, 16'hffff), 0, 3'd0};
    vecs[3] = '{16'h0000, mk(3, 16'h0000, 16'hffff), 0, 3'd0};
    vecs[4] = '{16'h0000, mk(3, 16'h0001, 16'hffff), 1, 3'd3};
    vecs[5] = '{16'h8000, mk(-1, 16'h0000, 16'h8000), 0, 3'd0};
    vecs[6] = '{16'h7ffe, mk(7, 16'h7fff, 16'h8000), 1, 3'd7};
    vecs[7] = '{16'hffff, mk(-1, 16'h0000, 16'h0000), 1, 3'd0};
    vecs[8] = '{16'h7fff, mk(-1, 16'h0000, 16'h7fff), 0, 3'd0};
    vecs[9] = '{16'h1000, mk(6, 16'h1001, 16'h0000), 1, 3'd2};
    vecs[9].beat[47:32] = 16'h1001;

    // reset held three cycles, then release
    do_reset(3);
    check("rst_tready", s_axis_tready, 1'b0);
    check("rst_done", cap_done, 1'b0);
    check("rst_rd_data", rd_data, 128'd0);
    cycle();
    check("post_rst_tready", s_axis_tready, 1'b1);
    check("post_rst_state", cap_state, ST_IDLE);

    // trigger-compare vector table
    for (int v = 0; v < 10; v++) begin
      do_reset(1);
      do_arm(vecs[v].level);
      send(vecs[v].beat);
      check("vec_trig", cap_state == ST_CAPTURE, vecs[v].exp_trig);
      if (vecs[v].exp_trig) begin
        check("vec_lane", trig_lane, vecs[v].exp_lane);
        check("vec_cnt", cap_cnt, 1);
      end
    end

    // level 0: -1 and 0 do not trigger, a later +1 does
    do_reset(1);
    do_arm(16'h0000);
    send(mk(-1, 16'h0000, 16'hffff));
    send(mk(-1, 16'h0000, 16'h0000));
    check("lvl0_armed", cap_state, ST_ARMED);
    send(mk(1, 16'h0001, 16'h0000));
    check("lvl0_trig", cap_state, ST_CAPTURE);
    check("lvl0_lane", trig_lane, 3'd1);

    // full capture with tvalid toggling, then ordered readout
    do_reset(1);
    do_arm(16'h1000);
    repeat (3) send(mk(-1, 16'h0000, 16'h0000));
    exp_q.delete();
    exp_q.push_back(mk(5, 16'h2000, 16'h0000));
    send(exp_q[0]);
    check("full_lane", trig_lane, 3'd5);
    check("full_cnt1", cap_cnt, 1);
    for (int c = 0; c < 510; c++) begin
      s_axis_tvalid = (c % 2 == 0);
      if (s_axis_tvalid) begin
        s_axis_tdata = rnd_beat();
        exp_q.push_back(s_axis_tdata);
      end
      cycle();
    end
    s_axis_tvalid = 0;
    check("full_done", cap_done, 1'b1);
    check("full_cnt", cap_cnt, DEPTH);
    send(rnd_beat());
    check("full_hold_cnt", cap_cnt, DEPTH);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = ADDR_W'(a);
      cycle();
      check("readout", rd_data, exp_q.pop_front());
    end

    // arm ignored mid-capture; reset aborts
    do_reset(1);
    do_arm(16'h0000);
    send(mk(0, 16'h0001, 16'h0000));
    repeat (9) send(rnd_beat());
    check("mid_cnt10", cap_cnt, 10);
    arm = 1; trig_level = 16'h7fff;
    send(rnd_beat());
    arm = 0;
    check("mid_cnt11", cap_cnt, 11);
    check("mid_state", cap_state, ST_CAPTURE);
    repeat (89) send(rnd_beat());
    check("mid_cnt100", cap_cnt, 100);
    do_reset(1);
    check("abort_state", cap_state, ST_IDLE);
    check("abort_cnt", cap_cnt, 0);

`ifdef ADC_CAPTURE_OVERRANGE_EN
    // full-scale alternating beats: every stored lane is overrange
    do_reset(1);
    do_arm(16'h7ffe);
    for (int k = 0; k < DEPTH; k++)
      send((k % 2 == 0) ? mk(-1, 16'h0, 16'h7fff) : mk(-1, 16'h0, 16'h8000));
    check("ovr_done", cap_done, 1'b1);
    check("ovr_cnt", overrange_cnt, 16'd2048);
`endif

    // randomized traffic against the model
    do_reset(1);
    for (int c = 0; c < 5000; c++) begin
      RESET = ($urandom_range(0, 1499) == 0);
      arm = ($urandom_range(0, 30) == 0);
      trig_level = 16'($urandom_range(16'h4000, 16'h7fff));
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata = rnd_beat();
      if ($urandom_range(0, 7) == 0) s_axis_tdata[15:0] = 16'h8000;
      if ($urandom_range(0, 7) == 0) s_axis_tdata[63:48] = 16'h7fff;
      rd_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      cycle();
    end
    RESET = 0; arm = 0; s_axis_tvalid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 256: capture buffer depth in 128-bit beats (power of two).
REQ-002 SHALL have parameter ADDR_W, default 8: log2(DEPTH).
REQ-003 SHALL have port adc_axi_clk  input  1: the only clock; all logic on its rising edge.
REQ-004 SHALL have port RESET  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port s_axis_tdata  input  128: 8 lanes of 16-bit signed two's-complement samples; lane i = bits [16i+15:16i], lane 0 oldest.
REQ-006 SHALL have port s_axis_tvalid  input  1: beat valid.
REQ-007 SHALL have port s_axis_tready  output  1: block can accept a beat.
REQ-008 SHALL have port arm  input  1: single-cycle pulse that starts a capture.
REQ-009 SHALL have port trig_level  input  16: signed threshold, sampled on the arm pulse.
REQ-010 SHALL have port cap_done  output  1: buffer holds a complete capture.
REQ-011 SHALL have port cap_cnt  output  ADDR_W+1: beats written in the current capture.
REQ-012 SHALL have port trig_lane  output  3: lowest lane index that met the trigger.
REQ-013 SHALL have port rd_addr  input  ADDR_W: readout address.
REQ-014 SHALL have port rd_data  output  128: buffer word at rd_addr, one-cycle latency.

Function
REQ-015 SHALL accept a beat only when s_axis_tvalid and s_axis_tready are both 1 in the same cycle.
REQ-016 SHALL drive s_axis_tready 1 in every state outside reset, discarding beats in IDLE and DONE so upstream never stalls.
REQ-017 SHALL implement the FSM states IDLE, ARMED, CAPTURE and DONE.
REQ-018 SHALL make these transitions:
  - IDLE to ARMED on arm.
  - DONE to ARMED on arm.
  - ARMED to CAPTURE on a trigger beat.
  - CAPTURE to DONE when cap_cnt reaches DEPTH.
REQ-019 SHALL ignore arm while in ARMED or CAPTURE.
REQ-020 SHALL, on arm, clear cap_done, cap_cnt and trig_lane and latch trig_level.
REQ-021 SHALL define a trigger beat as an accepted beat in ARMED where any lane, compared signed, is strictly greater than the latched level.
REQ-022 SHALL write the trigger beat at address 0 and make cap_cnt 1 in the next cycle.
REQ-023 SHALL write each subsequent accepted beat in CAPTURE at address cap_cnt[ADDR_W-1:0], then increment cap_cnt.
REQ-024 SHALL write no memory location while cap_cnt equals DEPTH.
REQ-025 SHALL assert cap_done in the cycle after the DEPTH-th write and hold it until arm or RESET.
REQ-026 SHALL make rd_data a registered read, valid one cycle after rd_addr, in every state.
REQ-027 SHALL, when a read and a write hit the same address in the same cycle, return the old contents on rd_data.
REQ-028 SHALL keep cycles without an accepted beat from advancing cap_cnt, and SHALL never let cap_cnt wrap.

Reset
REQ-029 SHALL, while RESET is 1, hold the FSM in IDLE with s_axis_tready=0, cap_done=0, cap_cnt=0, trig_lane=0, rd_data=0 and the latched level=0.
REQ-030 SHALL, when RESET asserts mid-capture, abort to IDLE with buffer contents undefined and not cleared.

Configuration
REQ-031 SHALL compile in a saturation-count feature when ADC_CAPTURE_OVERRANGE_EN is defined.
REQ-032 SHALL, with ADC_CAPTURE_OVERRANGE_EN defined, add output overrange_cnt (16 bits):
  - counts lanes equal to 16'h7fff or 16'h8000 across beats written in CAPTURE.
  - adds 0..8 per beat and saturates at 16'hffff.
  - is cleared on arm and by RESET.
REQ-033 SHALL, without ADC_CAPTURE_OVERRANGE_EN, have no overrange_cnt port and no counter logic.

Structure
REQ-034 SHALL place the FSM state enum, LANES=8 and SAMPLE_W=16 in the shared package adc_pkg.
REQ-035 SHALL use one sub-module adc_capture_ram: simple dual-port RAM, one write port, one registered read port, DEPTH x 128.
REQ-036 SHALL keep the trigger compare, the 8 parallel signed comparators and the priority encode combinational inside adc_capture.

Verification
REQ-037 SHALL cover: RESET held 3 cycles -> s_axis_tready=0 and cap_done=0; after release, tready=1 and state IDLE.
REQ-038 SHALL cover: arm with trig_level=16'h1000, beats of all-zero, then lane 5=16'h2000 -> trigger on that beat, trig_lane=5, word written at address 0, cap_cnt=1.
REQ-039 SHALL cover: after the trigger, 255 more beats with tvalid toggling every cycle -> cap_done=1 after the 256th write, and rd_addr=0..255 returns the beats in order.
REQ-040 SHALL cover: trig_level=16'h0000 with lane values 16'hffff (-1) and 16'h0000 -> no trigger; a later lane 16'h0001 -> trigger.
REQ-041 SHALL cover: arm pulse during CAPTURE at cap_cnt=10 -> ignored; cap_cnt continues to 11; RESET at cap_cnt=100 -> IDLE, cap_cnt=0.
REQ-042 SHALL cover, with ADC_CAPTURE_OVERRANGE_EN defined: capture of alternating beats with 8x16'h7fff and 8x16'h8000 (trig_level=16'h7ffe) -> overrange_cnt=2048 at cap_done.
